// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised FIFO: counter sizing and legality
// checks on the parameter set, evaluated at elaboration time.
package fifo_pkg;

    // Occupancy needs one bit more than a pointer so that DEPTH fits.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    // True when the whole parameter set describes a buildable FIFO.
    function automatic bit params_ok(input int width, input int depth,
                                     input int af_level, input int ae_level);
        return (width >= 1) && is_pow2(depth) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake bundle for sync_fifo_param. The master side
// is the stage driving requests; the slave side is the FIFO itself.
interface sync_fifo_param_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
);
    logic                      flush;
    logic                      wr_en;
    logic [WIDTH-1:0]          wr_data;
    logic                      rd_en;
    logic [WIDTH-1:0]          rd_data;
    logic                      rd_valid;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [cnt_w(DEPTH)-1:0]   count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output flush, wr_en, wr_data, rd_en,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wr_data, rd_en,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port register array: one synchronous write port and one
// synchronous read port with a registered output. A read and a write to
// the same address on the same edge return the old contents.
module fifo_sdp_ram #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write port.
    // NOTE: the array is deliberately left out of reset; only the output
    // register is cleared, so the storage maps onto plain flops or LUT RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its last word when not reading.
    // NOTE: non-blocking assignments are what give read-before-write here:
    // both processes sample mem before either update lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty levels, sticky error flags and synchronous flush.
// Pointers, count and flags live here; storage is in fifo_sdp_ram.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_param_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    if (!params_ok(WIDTH, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_param: illegal WIDTH/DEPTH/AF_LEVEL/AE_LEVEL");
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          rd_valid_q;
    logic          overflow_q;
    logic          underflow_q;

    logic          full_c;
    logic          empty_c;
    logic          rd_accept;
    logic          wr_accept;
    logic          ram_we;
    logic          ram_re;

    // Flags come straight from the registered count.
    assign full_c  = (count_q == DEPTH_C);
    assign empty_c = (count_q == '0);

    // A full FIFO still takes a write when a read frees a slot on the same
    // edge; an empty FIFO never forwards a same-cycle write to the reader.
    assign rd_accept = bus.rd_en & ~empty_c;
    assign wr_accept = bus.wr_en & (~full_c | rd_accept);

    // Flush (and reset) swallow any request in that cycle.
    assign ram_we = wr_accept & ~bus.flush & ~rst;
    assign ram_re = rd_accept & ~bus.flush;

    // Pointer, occupancy, read-valid and sticky error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            rd_valid_q  <= rd_accept;
            overflow_q  <= overflow_q  | (bus.wr_en & ~wr_accept);
            underflow_q <= underflow_q | (bus.rd_en & empty_c);
        end
    end

    fifo_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (bus.wr_data),
        .rd_en   (ram_re),
        .rd_addr (rd_ptr),
        .rd_data (bus.rd_data)
    );

    // Drive the status side of the bundle.
    always_comb begin
        bus.rd_valid     = rd_valid_q;
        bus.full         = full_c;
        bus.empty        = empty_c;
        bus.almost_full  = (count_q >= AF_C);
        bus.almost_empty = (count_q <= AE_C);
        bus.count        = count_q;
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
    end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (WIDTH=9, DEPTH=8, AF=6, AE=2).
// Inputs change 1 ns after a rising edge and outputs are sampled there too,
// so every check sees the state produced by the edge just taken.
module tb_sync_fifo_param;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    sync_fifo_param_if #(.WIDTH(9), .DEPTH(8)) bus ();

    sync_fifo_param #(
        .WIDTH    (9),
        .DEPTH    (8),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
    endtask

    task automatic push(input logic [8:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [8:0] exp);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check({tag, "_valid"}, 16'(bus.rd_valid), 16'd1);
        check({tag, "_data"},  16'(bus.rd_data),  16'(exp));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();

        // 1. Reset and idle.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_empty",     16'(bus.empty),        16'd1);
        check("rst_aempty",    16'(bus.almost_empty), 16'd1);
        check("rst_full",      16'(bus.full),         16'd0);
        check("rst_afull",     16'(bus.almost_full),  16'd0);
        check("rst_count",     16'(bus.count),        16'd0);
        check("rst_rd_valid",  16'(bus.rd_valid),     16'd0);
        check("rst_rd_data",   16'(bus.rd_data),      16'd0);
        check("rst_overflow",  16'(bus.overflow),     16'd0);
        check("rst_underflow", 16'(bus.underflow),    16'd0);

        // 2. Fill 0x001..0x008, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            push(9'(i));
            check($sformatf("fill_count%0d", i),  16'(bus.count),        16'(i));
            check($sformatf("fill_afull%0d", i),  16'(bus.almost_full),  16'(i >= 6));
            check($sformatf("fill_aempty%0d", i), 16'(bus.almost_empty), 16'(i <= 2));
            check($sformatf("fill_full%0d", i),   16'(bus.full),         16'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
            pop_check($sformatf("drain%0d", i), 9'(i));
            check($sformatf("drain_count%0d", i), 16'(bus.count),       16'(8 - i));
            check($sformatf("drain_afull%0d", i), 16'(bus.almost_full), 16'((8 - i) >= 6));
        end
        tick();
        check("drain_idle_valid", 16'(bus.rd_valid), 16'd0);
        check("drain_empty",      16'(bus.empty),    16'd1);

        // 3. Overflow while full, then write+read while full.
        for (int i = 1; i <= 8; i++) push(9'(i));
        bus.wr_en   = 1'b1;
        bus.wr_data = 9'h1FF;
        tick();
        bus.wr_en   = 1'b0;
        check("ovf_flag",  16'(bus.overflow), 16'd1);
        check("ovf_count", 16'(bus.count),    16'd8);
        check("ovf_valid", 16'(bus.rd_valid), 16'd0);
        bus.wr_en   = 1'b1;
        bus.wr_data = 9'h1FF;
        bus.rd_en   = 1'b1;
        tick();
        idle();
        check("full_rw_valid", 16'(bus.rd_valid), 16'd1);
        check("full_rw_data",  16'(bus.rd_data),  16'h001);
        check("full_rw_count", 16'(bus.count),    16'd8);
        for (int i = 2; i <= 8; i++) pop_check($sformatf("ovf_rd%0d", i), 9'(i));
        pop_check("ovf_rd_last", 9'h1FF);
        check("ovf_sticky", 16'(bus.overflow), 16'd1);
        check("ovf_empty",  16'(bus.empty),    16'd1);

        // 4. Read while empty with a same-cycle write: no bypass.
        bus.rd_en   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 9'h0AA;
        tick();
        idle();
        check("unf_flag",    16'(bus.underflow), 16'd1);
        check("unf_valid",   16'(bus.rd_valid),  16'd0);
        check("unf_count",   16'(bus.count),     16'd1);
        check("unf_hold",    16'(bus.rd_data),   16'h1FF);
        pop_check("unf_rd", 9'h0AA);
        check("unf_count0",  16'(bus.count),     16'd0);

        // 5. Wrap-around: 20 simultaneous write/read cycles at count=3.
        for (int i = 0; i < 3; i++) push(9'(12'h100 + i));
        for (int k = 0; k < 20; k++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 9'(12'h103 + k);
            bus.rd_en   = 1'b1;
            tick();
            check($sformatf("wrap_valid%0d", k), 16'(bus.rd_valid), 16'd1);
            check($sformatf("wrap_data%0d", k),  16'(bus.rd_data),  16'(12'h100 + k));
            check($sformatf("wrap_count%0d", k), 16'(bus.count),    16'd3);
        end
        idle();
        for (int k = 20; k < 23; k++) pop_check($sformatf("wrap_tail%0d", k), 9'(12'h100 + k));

        // 6. Flush with pending words, error flags set and a write request.
        for (int i = 0; i < 5; i++) push(9'(12'h050 + i));
        check("pre_flush_count", 16'(bus.count),     16'd5);
        check("pre_flush_ovf",   16'(bus.overflow),  16'd1);
        check("pre_flush_unf",   16'(bus.underflow), 16'd1);
        bus.flush   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_data = 9'h0FF;
        tick();
        idle();
        check("flush_count", 16'(bus.count),     16'd0);
        check("flush_empty", 16'(bus.empty),     16'd1);
        check("flush_ovf",   16'(bus.overflow),  16'd0);
        check("flush_unf",   16'(bus.underflow), 16'd0);
        check("flush_valid", 16'(bus.rd_valid),  16'd0);
        check("flush_hold",  16'(bus.rd_data),   16'h116);
        push(9'h033);
        check("post_flush_count", 16'(bus.count), 16'd1);
        pop_check("post_flush_rd", 9'h033);

        // Reset in the middle of a burst.
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        check("pre_rst_unf", 16'(bus.underflow), 16'd1);
        for (int i = 0; i < 6; i++) push(9'(12'h060 + i));
        bus.wr_en   = 1'b1;
        bus.wr_data = 9'h066;
        bus.rd_en   = 1'b1;
        rst         = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        check("mid_rst_count",  16'(bus.count),        16'd0);
        check("mid_rst_empty",  16'(bus.empty),        16'd1);
        check("mid_rst_aempty", 16'(bus.almost_empty), 16'd1);
        check("mid_rst_afull",  16'(bus.almost_full),  16'd0);
        check("mid_rst_full",   16'(bus.full),         16'd0);
        check("mid_rst_valid",  16'(bus.rd_valid),     16'd0);
        check("mid_rst_data",   16'(bus.rd_data),      16'd0);
        check("mid_rst_ovf",    16'(bus.overflow),     16'd0);
        check("mid_rst_unf",    16'(bus.underflow),    16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO. It is the next-generation buffer for 9-bit datapath stages and replaces hand-sized 8-entry arrays.
- Adds the following over the previous generation:
  - full and empty flags
  - occupancy count
  - programmable almost-full and almost-empty thresholds
  - sticky overflow and underflow error flags
  - a synchronous flush
- Sits between producer and consumer stages in the same clock domain.

Parameters:
- WIDTH, 9: data word width in bits (at least 1).
- DEPTH, 8: number of entries. Must be a power of 2 and at least 2.
- AF_LEVEL, 6: almost_full asserts when count is at least AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count is at most AE_LEVEL. Range 0..DEPTH-1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of pointers, count and error flags. Memory contents are not cleared.
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  high for one cycle when rd_data holds a newly popped word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full and was not accepted
- underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst=1 at a clock edge), required state after the edge:
  - wr_ptr=0, rd_ptr=0, count=0
  - rd_data=0, rd_valid=0
  - overflow=0, underflow=0
  - empty=1, full=0, almost_empty=1, almost_full=0 (given AF_LEVEL>=1)
- Priority order: rst > flush > normal operation.
- flush:
  - Same register effect as reset, except rd_data holds its previous value.
  - Any wr_en or rd_en in the flush cycle is ignored and does not set an error flag.
- Accept rules, evaluated on the pre-edge state:
  - rd_accept = rd_en & ~empty.
  - wr_accept = wr_en & (~full | rd_accept). Write while full succeeds only with a simultaneous accepted read.
  - No write-to-read bypass: a read while empty is rejected even if a write is in the same cycle.
- Pointers:
  - Widths are $clog2(DEPTH) bits.
  - Each pointer increments by 1 on accept and wraps DEPTH-1 -> 0 naturally.
- count update:
  - +1 on write-only accept.
  - -1 on read-only accept.
  - Unchanged when both are accepted or neither is.
  - count never exceeds DEPTH and never goes below 0.
- Write: on wr_accept, mem[wr_ptr] <= wr_data at the edge.
- Read latency:
  - On rd_accept, at the same edge rd_data <= mem[rd_ptr] and rd_valid <= 1.
  - Data is therefore visible in the cycle after rd_en is sampled.
  - Otherwise rd_valid <= 0 and rd_data holds its last value. The output is never driven to Z.
- Simultaneous read and write at the same address (count==0 cannot read; count==DEPTH means write and read hit the same slot):
  - The read returns the old contents.
  - Memory is read-before-write.
- Flags:
  - All flags are derived combinationally from the registered count, so they update the cycle after the causing edge.
- Error flags:
  - overflow <= 1 when wr_en & ~wr_accept.
  - underflow <= 1 when rd_en & empty.
  - Both remain set until rst or flush.
  - A rejected access has no other effect: no pointer, count or memory change.

Decomposition:
- Package fifo_pkg holds:
  - function cnt_w(depth) returning $clog2(depth)+1
  - elaboration-time parameter checks (DEPTH a power of 2; AF_LEVEL and AE_LEVEL in range), which error out on illegal values
- Sub-module fifo_sdp_ram:
  - simple dual-port register array, parameters WIDTH and DEPTH
  - one synchronous write port, one synchronous read port with registered output
  - read-before-write on an address collision
- The top level holds the pointers, count, flags and control.

Test Plan (WIDTH=9, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2 unless noted):
1. Reset, then idle -> empty=1, almost_empty=1, count=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
2. Write 0x001..0x008 on consecutive cycles, then read 8 -> count steps 1..8 then back to 0; almost_full=1 from count=6; full=1 at count=8; reads return 0x001..0x008 in order, each one cycle after rd_en, with rd_valid=1 on those 8 cycles.
3. Fill to 8, then wr_en=1 with wr_data=0x1FF and rd_en=0 -> overflow=1, count stays 8, later reads return 0x001..0x008 with no 0x1FF. Then wr_en=1 and rd_en=1 while full -> both accepted, count=8, 0x1FF is read last.
4. Empty FIFO, rd_en=1 together with wr_en=1 and wr_data=0x0AA -> underflow=1, rd_valid=0, count=1; the next read returns 0x0AA.
5. Wrap-around: 20 cycles of simultaneous write and read starting at count=3 -> count stays 3, data order is preserved across pointer wrap, rd_valid=1 on every cycle.
6. Write 5 words with an error flag set, then flush=1 together with wr_en=1 -> count=0, empty=1, overflow=0, underflow=0, the write is dropped, and rd_data keeps its last value. Also assert rst in the middle of a burst -> all outputs reach their reset values at the next edge.
